mesh_noc_ni: RTL

MESH_NOC_NI -- requirements
Module: mesh_noc_ni

---
 rtl/mesh_noc_ni_pkg.sv | 38 +++
 rtl/mesh_noc_ni_fifo.sv | 59 +++++
 rtl/mesh_noc_ni.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mesh_noc_ni_pkg.sv
// -----------------------------------------------------------------------------
// mesh_noc_ni_pkg
//   Shared definitions for the mesh network interface:
//     - packet field width / offset helpers (layout is {data, row, col},
//       col in the LSBs)
//     - TX state machine encoding
//     - bit indices of the sticky error vector
// -----------------------------------------------------------------------------
package mesh_noc_ni_pkg;

   // TX path state machine
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_SEND  = 2'd1,
      TX_STALL = 2'd2
   } tx_state_e;

   // Sticky error vector bit positions
   localparam int ERR_TX_OVRFLW = 0;  // mesh reported overflow of its input FIFO
   localparam int ERR_RX_OVRFLW = 1;  // packet arrived while RX FIFO full
   localparam int ERR_MISROUTE  = 2;  // packet arrived addressed to another node

   // Total packet width
   function automatic int pckt_width(input int data_w, input int row_w, input int col_w);
      return data_w + row_w + col_w;
   endfunction

   // LSB position of the row field
   function automatic int row_lsb(input int col_w);
      return col_w;
   endfunction

   // LSB position of the payload field
   function automatic int data_lsb(input int row_w, input int col_w);
      return row_w + col_w;
   endfunction

endpackage

// File: rtl/mesh_noc_ni_fifo.sv
// -----------------------------------------------------------------------------
// ni_sync_fifo
//   Single-clock first-word-fall-through FIFO with 2**DEPTH_W entries.
//   Pointers carry one extra MSB so full and empty are distinguishable.
//   Ports:
//     clk, rst     clock, synchronous active-high reset (empties the FIFO)
//     push, din    write request and data; ignored while full
//     pop          read request; ignored while empty
//     head         oldest entry (valid while !empty)
//     full, empty  occupancy flags
// -----------------------------------------------------------------------------
module ni_sync_fifo #(
   parameter int WIDTH   = 8,
   parameter int DEPTH_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 2 ** DEPTH_W;
   localparam logic [DEPTH_W:0] PTR_ONE = {{DEPTH_W{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH_W:0] wr_ptr;
   logic [DEPTH_W:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Same index with different wrap bit means the writer is a lap ahead.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[DEPTH_W] != rd_ptr[DEPTH_W]) &&
                  (wr_ptr[DEPTH_W-1:0] == rd_ptr[DEPTH_W-1:0]);
   assign head  = mem[rd_ptr[DEPTH_W-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (do_push && !rst) mem[wr_ptr[DEPTH_W-1:0]] <= din;
   end

endmodule

// File: rtl/mesh_noc_ni.sv
// -----------------------------------------------------------------------------
// mesh_noc_ni
//   Network interface between a resource and one node of a ROW_N x COL_M mesh.
//
//   TX: resource messages {data,row,col} are queued in a TX FIFO, moved into an
//       output register and written to the mesh with a one-cycle ni_wren_o
//       strobe while the mesh is not full. Stalls hold the packet.
//   RX: packets from the mesh are checked against this node's coordinates;
//       matching payloads go into an FWFT RX FIFO, misrouted ones are dropped,
//       packets arriving while the RX FIFO is full are dropped and reported
//       with a registered ni_ovrflw_o pulse.
//
//   Handshakes: tx side transfers when tx_valid_i && tx_ready_o on a rising
//   edge; rx side transfers when rx_valid_o && rx_ready_i on a rising edge.
//   Valid never depends on ready. The mesh side is strobe based: ni_wren_o /
//   noc_wren_i each mean "one packet this cycle", throttled by the full flags.
//
//   Ports:
//     clk_i, rst_i                      clock, synchronous active-high reset
//     tx_valid_i/tx_ready_o             resource TX handshake
//     tx_row_i, tx_col_i, tx_data_i     destination and payload
//     ni_pckt_o, ni_wren_o              packet and strobe into the mesh
//     noc_full_i, noc_ovrflw_i          mesh input FIFO status
//     noc_pckt_i, noc_wren_i            packet and strobe from the mesh
//     ni_full_o, ni_ovrflw_o            RX FIFO status back to the mesh
//     rx_valid_o/rx_ready_i, rx_data_o  resource RX handshake and payload
//     err_o                             sticky {misroute, rx_ovrflw, tx_ovrflw}
//     tx_cnt_o, rx_cnt_o                wrapping packet counters
// -----------------------------------------------------------------------------
module mesh_noc_ni
   import mesh_noc_ni_pkg::*;
#(
   parameter int ROW_N        = 3,
   parameter int COL_M        = 3,
   parameter int PCKT_DATA_W  = 8,
   parameter int FIFO_DEPTH_W = 2,
   parameter int ROW_CORD     = 0,
   parameter int COL_CORD     = 0,
   localparam int ROW_W  = $clog2(ROW_N),
   localparam int COL_W  = $clog2(COL_M),
   localparam int PCKT_W = pckt_width(PCKT_DATA_W, ROW_W, COL_W)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   tx_valid_i,
   output logic                   tx_ready_o,
   input  logic [ROW_W-1:0]       tx_row_i,
   input  logic [COL_W-1:0]       tx_col_i,
   input  logic [PCKT_DATA_W-1:0] tx_data_i,
   output logic [PCKT_W-1:0]      ni_pckt_o,
   output logic                   ni_wren_o,
   input  logic                   noc_full_i,
   input  logic                   noc_ovrflw_i,
   input  logic [PCKT_W-1:0]      noc_pckt_i,
   input  logic                   noc_wren_i,
   output logic                   ni_full_o,
   output logic                   ni_ovrflw_o,
   output logic                   rx_valid_o,
   input  logic                   rx_ready_i,
   output logic [PCKT_DATA_W-1:0] rx_data_o,
   output logic [2:0]             err_o,
   output logic [15:0]            tx_cnt_o,
   output logic [15:0]            rx_cnt_o
);

   localparam int ROW_LSB  = row_lsb(COL_W);
   localparam int DATA_LSB = data_lsb(ROW_W, COL_W);
   localparam logic [ROW_W-1:0] OWN_ROW = ROW_W'(ROW_CORD);
   localparam logic [COL_W-1:0] OWN_COL = COL_W'(COL_CORD);

   // ---------------------------------------------------------------- TX path
   tx_state_e          tx_state_q, tx_state_d;
   logic               tx_full, tx_empty;
   logic [PCKT_W-1:0]  tx_head;
   logic               tx_push, tx_pop, tx_load, tx_wren;
   logic [PCKT_W-1:0]  pckt_q;
   logic [15:0]        tx_cnt_q;

   // Ready is forced high during reset; the FIFO is held empty then anyway.
   assign tx_ready_o = !tx_full || rst_i;
   assign tx_push    = tx_valid_i && tx_ready_o && !rst_i;

   ni_sync_fifo #(
      .WIDTH   (PCKT_W),
      .DEPTH_W (FIFO_DEPTH_W)
   ) u_tx_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (tx_push),
      .din   ({tx_data_i, tx_row_i, tx_col_i}),
      .pop   (tx_pop),
      .head  (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) tx_state_q <= TX_IDLE;
      else       tx_state_q <= tx_state_d;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_pop     = 1'b0;
      tx_load    = 1'b0;
      tx_wren    = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_load    = 1'b1;
               tx_state_d = TX_SEND;
            end
         end
         TX_SEND: begin
            if (noc_full_i) begin
               tx_state_d = TX_STALL;
            end else begin
               tx_wren = 1'b1;
               // Refill the output register in the write cycle so queued
               // packets go out on consecutive cycles.
               if (!tx_empty) begin
                  tx_pop  = 1'b1;
                  tx_load = 1'b1;
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end
         end
         TX_STALL: begin
            if (!noc_full_i) tx_state_d = TX_SEND;
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pckt_q   <= '0;
         tx_cnt_q <= '0;
      end else begin
         if (tx_load) pckt_q   <= tx_head;
         if (tx_wren) tx_cnt_q <= tx_cnt_q + 16'd1;
      end
   end

   // Strobe is combinational from the held state, so it can never coincide
   // with noc_full_i and needs no extra pipeline stage.
   assign ni_wren_o = tx_wren && !rst_i;
   assign ni_pckt_o = pckt_q;
   assign tx_cnt_o  = tx_cnt_q;

   // ---------------------------------------------------------------- RX path
   logic [ROW_W-1:0]       rx_row;
   logic [COL_W-1:0]       rx_col;
   logic [PCKT_DATA_W-1:0] rx_payload;
   logic                   rx_full, rx_empty;
   logic                   rx_match, rx_push, rx_pop;
   logic                   rx_drop_full, rx_misroute;
   logic                   ovrflw_q;
   logic [2:0]             err_q;
   logic [15:0]            rx_cnt_q;

   assign rx_col     = noc_pckt_i[COL_W-1:0];
   assign rx_row     = noc_pckt_i[ROW_LSB +: ROW_W];
   assign rx_payload = noc_pckt_i[DATA_LSB +: PCKT_DATA_W];
   assign rx_match   = (rx_row == OWN_ROW) && (rx_col == OWN_COL);

   // Fullness is judged before any same-cycle pop: a push into a full FIFO is
   // an overflow even if the resource drains an entry in that cycle.
   assign rx_drop_full = noc_wren_i && rx_full && !rst_i;
   assign rx_misroute  = noc_wren_i && !rx_full && !rx_match && !rst_i;
   assign rx_push      = noc_wren_i && !rx_full && rx_match && !rst_i;
   assign rx_pop       = rx_valid_o && rx_ready_i;

   ni_sync_fifo #(
      .WIDTH   (PCKT_DATA_W),
      .DEPTH_W (FIFO_DEPTH_W)
   ) u_rx_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (rx_push),
      .din   (rx_payload),
      .pop   (rx_pop),
      .head  (rx_data_o),
      .full  (rx_full),
      .empty (rx_empty)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovrflw_q <= 1'b0;
         err_q    <= '0;
         rx_cnt_q <= '0;
      end else begin
         ovrflw_q <= rx_drop_full;
         if (noc_ovrflw_i) err_q[ERR_TX_OVRFLW] <= 1'b1;
         if (rx_drop_full) err_q[ERR_RX_OVRFLW] <= 1'b1;
         if (rx_misroute)  err_q[ERR_MISROUTE]  <= 1'b1;
         if (rx_pop)       rx_cnt_q <= rx_cnt_q + 16'd1;
      end
   end

   assign ni_full_o   = rx_full && !rst_i;
   assign rx_valid_o  = !rx_empty && !rst_i;
   assign ni_ovrflw_o = ovrflw_q;
   assign err_o       = err_q;
   assign rx_cnt_o    = rx_cnt_q;

endmodule
